// File: rtl/fpro_bus_arbiter_pkg.sv
// rtl/fpro_bus_arbiter_pkg.sv - shared types and default widths for the FPro bus arbiter
package fpro_arb_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/fpro_bus_arbiter_if.sv
// rtl/fpro_bus_arbiter_if.sv - FPro MMIO bus bundle between the arbiter and the MMIO subsystem
interface fpro_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);

  logic              fp_mmio_cs;
  logic              fp_wr;
  logic              fp_rd;
  logic [ADDR_W-1:0] fp_addr;
  logic [DATA_W-1:0] fp_wr_data;
  logic [DATA_W-1:0] fp_rd_data;

  modport master (
    output fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    input  fp_rd_data
  );

  modport slave (
    input  fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    output fp_rd_data
  );

endinterface

// File: rtl/fpro_bus_arbiter_rr_arb2.sv
// rtl/fpro_bus_arbiter_rr_arb2.sv - combinational two-way winner select
module rr_arb2 #(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    // A tie goes to whoever did not win last time; fixed mode always favours master 0.
    if (req == 2'b11) begin
      gnt_idx = (RR_EN != 0) ? ~last_grant : 1'b0;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// rtl/fpro_bus_arbiter.sv - two-master arbiter serialising single-cycle FPro MMIO bus transactions
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rd_data,
  fpro_bus_arbiter_if.master bus,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic              busy
);

  state_t              state_q, state_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic                cmd_idx_q, cmd_idx_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;
  logic                gnt_valid;
  logic                gnt_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  rr_arb2 #(.RR_EN(RR_EN)) u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_wr_q     <= 1'b0;
      cmd_idx_q    <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      last_grant_q <= 1'b1;
      rd_data_q    <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_idx_q    <= cmd_idx_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      last_grant_q <= last_grant_d;
      rd_data_q    <= rd_data_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_wr_d     = cmd_wr_q;
    cmd_idx_d    = cmd_idx_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    last_grant_d = last_grant_q;
    rd_data_d    = rd_data_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    // The winner's command is frozen here so late master-side changes cannot reach the bus.
    if (state_q == IDLE && gnt_valid) begin
      cmd_idx_d    = gnt_idx;
      last_grant_d = gnt_idx;
      cmd_wr_d     = gnt_idx ? m1_wr      : m0_wr;
      cmd_addr_d   = gnt_idx ? m1_addr    : m0_addr;
      cmd_data_d   = gnt_idx ? m1_wr_data : m0_wr_data;
    end
    if (state_q == ISSUE && !cmd_wr_q) begin
      rd_data_d = bus.fp_rd_data;
    end
    if (state_q == ACK) begin
      if (cmd_idx_q) cnt1_d = sat_inc(cnt1_q);
      else           cnt0_d = sat_inc(cnt0_q);
    end
  end

  always_comb begin
    bus.fp_mmio_cs = 1'b0;
    bus.fp_wr      = 1'b0;
    bus.fp_rd      = 1'b0;
    bus.fp_addr    = '0;
    bus.fp_wr_data = '0;
    m0_ack         = 1'b0;
    m1_ack         = 1'b0;
    if (state_q == ISSUE) begin
      bus.fp_mmio_cs = 1'b1;
      bus.fp_wr      = cmd_wr_q;
      bus.fp_rd      = ~cmd_wr_q;
      bus.fp_addr    = cmd_addr_q;
      bus.fp_wr_data = cmd_data_q;
    end
    if (state_q == ACK) begin
      m0_ack = ~cmd_idx_q;
      m1_ack = cmd_idx_q;
    end
    busy       = (state_q != IDLE);
    rd_data    = rd_data_q;
    grant_cnt0 = cnt0_q;
    grant_cnt1 = cnt1_q;
  end

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// tb/tb_fpro_bus_arbiter.sv - self-checking bench for fpro_bus_arbiter
module tb_fpro_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_wr, m1_wr;
  logic [20:0] m0_addr, m1_addr;
  logic [31:0] m0_wr_data, m1_wr_data;
  logic [31:0] rdd;

  logic        a_ack0, a_ack1, a_busy;
  logic [31:0] a_rd_data;
  logic [15:0] a_cnt0, a_cnt1;
  logic        b_ack0, b_ack1, b_busy;
  logic [31:0] b_rd_data;
  logic [1:0]  b_cnt0, b_cnt1;

  int checks = 0;
  int errors = 0;

  fpro_bus_arbiter_if #(.ADDR_W(21), .DATA_W(32)) bus_a ();
  fpro_bus_arbiter_if #(.ADDR_W(21), .DATA_W(32)) bus_b ();
  assign bus_a.fp_rd_data = rdd;
  assign bus_b.fp_rd_data = rdd;

  fpro_bus_arbiter #(.ADDR_W(21), .DATA_W(32), .CNT_W(16), .RR_EN(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
    .m0_ack(a_ack0), .m1_ack(a_ack1), .rd_data(a_rd_data), .bus(bus_a.master),
    .grant_cnt0(a_cnt0), .grant_cnt1(a_cnt1), .busy(a_busy)
  );

  fpro_bus_arbiter #(.ADDR_W(21), .DATA_W(32), .CNT_W(2), .RR_EN(0)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
    .m0_ack(b_ack0), .m1_ack(b_ack1), .rd_data(b_rd_data), .bus(bus_b.master),
    .grant_cnt0(b_cnt0), .grant_cnt1(b_cnt1), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [20:0] a0;
    logic [20:0] a1;
    logic [31:0] wd1;
    logic [31:0] rdd;
    logic        ecs;
    logic        ewr;
    logic [20:0] eaddr;
    logic [31:0] ewd;
    logic [1:0]  eack;
    logic [31:0] erd;
    logic [15:0] ec0;
    logic [15:0] ec1;
  } vec_t;

  localparam logic [31:0] WD0 = 32'hC0FF_EE00;

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] wr,
                              input logic [20:0] a0, input logic [20:0] a1,
                              input logic [31:0] wd1, input logic [31:0] rd_in,
                              input logic ecs, input logic ewr, input logic [20:0] eaddr,
                              input logic [31:0] ewd, input logic [1:0] eack,
                              input logic [31:0] erd, input logic [15:0] ec0,
                              input logic [15:0] ec1);
    vec_t v;
    v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.wd1 = wd1; v.rdd = rd_in;
    v.ecs = ecs; v.ewr = ewr; v.eaddr = eaddr; v.ewd = ewd; v.eack = eack;
    v.erd = erd; v.ec0 = ec0; v.ec1 = ec1;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wr_data = WD0; m1_wr_data = '0; rdd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Transaction-level reference for the random phase: one outstanding grant, 3-cycle service.
  int          free_at, t_grant, k;
  bit          have_txn;
  logic        t_idx, t_wr, model_last;
  logic [20:0] t_addr;
  logic [31:0] t_wd, model_rd;
  int          model_cnt[2];

  initial begin
    vec_t tbl[$];
    int   n0, last_m0_ack, m1_ack_at, waited;
    logic exp_cs, exp_a0, exp_a1, w;
    logic cur_a0, cur_a1;

    tbl.push_back(mk(2'b01, 2'b00, 21'h40,    21'h0,   32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b00, 32'h0,        16'd0, 16'd0));
    tbl.push_back(mk(2'b01, 2'b00, 21'h1FFFF, 21'h0,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 21'h40,  WD0,          2'b00, 32'h0,        16'd0, 16'd0));
    tbl.push_back(mk(2'b00, 2'b00, 21'h1FFFF, 21'h0,   32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b01, 32'hDEADBEEF, 16'd0, 16'd0));
    tbl.push_back(mk(2'b10, 2'b10, 21'h0,     21'h81,  32'h12345678, 32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b00, 32'hDEADBEEF, 16'd1, 16'd0));
    tbl.push_back(mk(2'b10, 2'b10, 21'h0,     21'h81,  32'hFFFFFFFF, 32'h55555555, 1'b1, 1'b1, 21'h81,  32'h12345678, 2'b00, 32'hDEADBEEF, 16'd1, 16'd0));
    tbl.push_back(mk(2'b00, 2'b00, 21'h0,     21'h0,   32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b10, 32'hDEADBEEF, 16'd1, 16'd0));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b00, 32'hDEADBEEF, 16'd1, 16'd1));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'hA0,       1'b1, 1'b0, 21'h100, WD0,          2'b00, 32'hDEADBEEF, 16'd1, 16'd1));
    tbl.push_back(mk(2'b10, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b01, 32'hA0,       16'd1, 16'd1));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b00, 32'hA0,       16'd2, 16'd1));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'hA1,       1'b1, 1'b0, 21'h200, 32'h0,        2'b00, 32'hA0,       16'd2, 16'd1));
    tbl.push_back(mk(2'b01, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b10, 32'hA1,       16'd2, 16'd1));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b00, 32'hA1,       16'd2, 16'd2));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'hA2,       1'b1, 1'b0, 21'h100, WD0,          2'b00, 32'hA1,       16'd2, 16'd2));
    tbl.push_back(mk(2'b10, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b01, 32'hA2,       16'd2, 16'd2));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b00, 32'hA2,       16'd3, 16'd2));
    tbl.push_back(mk(2'b11, 2'b00, 21'h100,   21'h200, 32'h0,        32'hA3,       1'b1, 1'b0, 21'h200, 32'h0,        2'b00, 32'hA2,       16'd3, 16'd2));
    tbl.push_back(mk(2'b00, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b10, 32'hA3,       16'd3, 16'd2));
    tbl.push_back(mk(2'b00, 2'b00, 21'h100,   21'h200, 32'h0,        32'h0,        1'b0, 1'b0, 21'h0,   32'h0,        2'b00, 32'hA3,       16'd3, 16'd3));

    // Reset state
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst cs", bus_a.fp_mmio_cs, 0);
    chk("rst busy", a_busy, 0);
    chk("rst rd_data", a_rd_data, 0);
    chk("rst cnt0", a_cnt0, 0);
    chk("rst cnt1", a_cnt1, 0);
    chk("rst acks", {a_ack1, a_ack0, b_ack1, b_ack0}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single read, single write, round-robin contention
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d cs", i), bus_a.fp_mmio_cs, tbl[i].ecs);
      chk($sformatf("v%0d wr", i), bus_a.fp_wr, tbl[i].ecs & tbl[i].ewr);
      chk($sformatf("v%0d rd", i), bus_a.fp_rd, tbl[i].ecs & ~tbl[i].ewr);
      chk($sformatf("v%0d addr", i), bus_a.fp_addr, tbl[i].eaddr);
      chk($sformatf("v%0d wdata", i), bus_a.fp_wr_data, tbl[i].ewd);
      chk($sformatf("v%0d acks", i), {a_ack1, a_ack0}, tbl[i].eack);
      chk($sformatf("v%0d rd_data", i), a_rd_data, tbl[i].erd);
      chk($sformatf("v%0d busy", i), a_busy, tbl[i].ecs | (|tbl[i].eack));
      chk($sformatf("v%0d cnt0", i), a_cnt0, tbl[i].ec0);
      chk($sformatf("v%0d cnt1", i), a_cnt1, tbl[i].ec1);
      m0_req = tbl[i].req[0]; m1_req = tbl[i].req[1];
      m0_wr = tbl[i].wr[0];   m1_wr = tbl[i].wr[1];
      m0_addr = tbl[i].a0;    m1_addr = tbl[i].a1;
      m0_wr_data = WD0;       m1_wr_data = tbl[i].wd1;
      rdd = tbl[i].rdd;
    end

    // Fixed priority (dut_b): m0 re-requests 5 times, m1 holds req throughout; CNT_W=2 saturates
    do_reset();
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h3; m1_wr_data = 32'h0BAD_F00D;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h10;
    n0 = 0; last_m0_ack = -10; m1_ack_at = -1;
    for (int c = 0; c < 60 && m1_ack_at < 0; c++) begin
      @(negedge clk);
      if (b_ack0) begin
        n0++; last_m0_ack = c; m0_req = 1'b0;
      end else if (b_ack1) begin
        m1_ack_at = c; m1_req = 1'b0;
        chk("fixed m0 acks before m1", n0, 5);
        chk("fixed m1 ack latency", c - last_m0_ack, 3);
      end else if (!m0_req && n0 < 5) begin
        m0_req = 1'b1;
      end
    end
    chk("fixed m1 acked in bound", m1_ack_at >= 0, 1);
    @(negedge clk);
    chk("sat cnt0", b_cnt0, 2'd3);
    chk("fixed cnt1", b_cnt1, 2'd1);

    // Randomised traffic on dut_a against the transaction model
    do_reset();
    free_at = 0; have_txn = 0; t_grant = -10; model_last = 1'b1;
    model_rd = '0; model_cnt[0] = 0; model_cnt[1] = 0;
    t_idx = 1'b0; t_wr = 1'b0; t_addr = '0; t_wd = '0;
    for (k = 0; k < 1500; k++) begin
      @(negedge clk);
      exp_cs = have_txn && (k == t_grant + 1);
      exp_a0 = have_txn && (k == t_grant + 2) && !t_idx;
      exp_a1 = have_txn && (k == t_grant + 2) && t_idx;
      chk("rnd cs", bus_a.fp_mmio_cs, exp_cs);
      chk("rnd acks", {a_ack1, a_ack0}, {exp_a1, exp_a0});
      chk("rnd busy", a_busy, exp_cs | exp_a0 | exp_a1);
      chk("rnd rd_data", a_rd_data, model_rd);
      chk("rnd cnt0", a_cnt0, 16'(model_cnt[0]));
      chk("rnd cnt1", a_cnt1, 16'(model_cnt[1]));
      if (exp_cs) begin
        chk("rnd strobes", {bus_a.fp_wr, bus_a.fp_rd}, {t_wr, ~t_wr});
        chk("rnd addr", bus_a.fp_addr, t_addr);
        chk("rnd wdata", bus_a.fp_wr_data, t_wd);
      end else begin
        chk("rnd idle bus", {bus_a.fp_wr, bus_a.fp_rd, bus_a.fp_addr, bus_a.fp_wr_data}, 0);
      end
      if (exp_a0) model_cnt[0]++;
      if (exp_a1) model_cnt[1]++;
      cur_a0 = a_ack0; cur_a1 = a_ack1;
      if (cur_a0) m0_req = 1'b0;
      else if (!m0_req && $urandom_range(0, 3) == 0) m0_req = 1'b1;
      if (cur_a1) m1_req = 1'b0;
      else if (!m1_req && $urandom_range(0, 3) == 0) m1_req = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        m0_wr = 1'($urandom); m0_addr = 21'($urandom); m0_wr_data = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        m1_wr = 1'($urandom); m1_addr = 21'($urandom); m1_wr_data = $urandom;
      end
      rdd = $urandom;
      if (exp_cs && !t_wr) model_rd = rdd;
      if (k >= free_at && (m0_req || m1_req)) begin
        if (m0_req && m1_req) w = ~model_last;
        else                  w = m1_req;
        model_last = w;
        have_txn = 1; t_grant = k; free_at = k + 3; t_idx = w;
        t_wr   = w ? m1_wr      : m0_wr;
        t_addr = w ? m1_addr    : m0_addr;
        t_wd   = w ? m1_wr_data : m0_wr_data;
      end
    end

    // Reset asserted during the bus cycle
    m0_req = 1'b0; m1_req = 1'b0;
    waited = 0;
    while (a_busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h44;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus_a.fp_mmio_cs && waited < 10);
    chk("rst-issue reached cs", bus_a.fp_mmio_cs, 1);
    reset = 1'b1;
    #1;
    chk("rst-issue cs", bus_a.fp_mmio_cs, 0);
    chk("rst-issue rd", bus_a.fp_rd, 0);
    chk("rst-issue busy", a_busy, 0);
    chk("rst-issue ack", {a_ack1, a_ack0}, 0);
    chk("rst-issue cnts", {a_cnt1, a_cnt0}, 0);
    m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post-rst idle", {bus_a.fp_mmio_cs, a_busy, a_ack1, a_ack0}, 0);
    end
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h7; m0_wr_data = 32'h1;
    @(negedge clk);
    m0_req = 1'b0;
    chk("post-rst first grant cs", bus_a.fp_mmio_cs, 1);
    @(negedge clk);
    chk("post-rst first ack", {a_ack1, a_ack0}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpro_bus_arbiter.md
# fpro_bus_arbiter

Two-master arbiter that shares the single FPro MMIO bus (cs/wr/rd/addr/wr_data/rd_data) feeding the MMIO I/O subsystem. Master 0 is the MicroBlaze MCS bridge; master 1 is a hardware requester, e.g. an autonomous sensor-sampling sequencer. Each master uses a req/ack handshake. The arbiter serialises transactions, drives exactly one bus cycle per grant, registers read data and returns it with the ack. It sits between the bridge/sequencer and the MMIO subsystem in the top level.

## Interface
Parameters:
- ADDR_W, 21, FPro address width
- DATA_W, 32, data width
- CNT_W, 16, width of per-master saturating grant counters
- RR_EN, 1, 1 = round-robin; 0 = fixed priority, master 0 wins

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  request; holds until the matching ack
- m0_wr, m1_wr  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  target address
- m0_wr_data, m1_wr_data  in  DATA_W  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- rd_data  out  DATA_W  registered read data; valid in the ack cycle
- fp_mmio_cs  out  1  bus select
- fp_wr, fp_rd  out  1  bus strobes
- fp_addr  out  ADDR_W  bus address
- fp_wr_data  out  DATA_W  bus write data
- fp_rd_data  in  DATA_W  bus read data, combinational from the slave
- grant_cnt0, grant_cnt1  out  CNT_W  completed transactions per master, saturating
- busy  out  1  high in ISSUE and ACK

## Operation
- FSM states: IDLE, ISSUE, ACK.
- IDLE: if any req is high, choose a winner, latch its wr/addr/wr_data and its index into cmd registers, update last_grant, go to ISSUE. Otherwise stay in IDLE.
- Winner with RR_EN=1: a single requester always wins. If both request, the master not equal to last_grant wins.
- Winner with RR_EN=0: master 0 wins whenever m0_req is high.
- ISSUE: fp_mmio_cs=1. fp_wr = latched wr, fp_rd = !latched wr. fp_addr and fp_wr_data come from the latched values. On reads, capture fp_rd_data into rd_data at the clock edge. Go to ACK.
- ACK: pulse the granted master's ack for one cycle. Increment its grant counter, saturating at all-ones. Go to IDLE.
- Requests are sampled only in IDLE. The command is latched, so changes to m*_addr, m*_wr or m*_wr_data after the IDLE cycle have no effect.
- A master must keep req high until its ack. Dropping req early does not cancel the latched transaction; the ack is still issued.
- Masters must lower req in the cycle after their ack. A req still high in the IDLE that follows is treated as a new request.
- rd_data holds its value until the next read capture. On writes, rd_data is unchanged.
- All fp_* outputs are 0 outside ISSUE. The bus is never driven for two consecutive cycles.

## Timing
- Reset values: all outputs 0, state=IDLE, last_grant=1 (so master 0 wins the first tie), counters 0, cmd registers 0.
- Latency: req seen in IDLE at cycle n → bus strobe at n+1 → ack and rd_data at n+2. Earliest next IDLE is n+3.
- Throughput: one transaction every 3 cycles. With both masters continuously requesting and RR_EN=1, grants alternate 0,1,0,1.
- Simultaneous req from both masters: exactly one is granted. The other's req stays pending and is granted in the next IDLE.
- Reset asserted in ISSUE or ACK: outputs go to 0 asynchronously, no ack is emitted, and the FSM is in IDLE after reset is released.
- Counter saturation: at 2^CNT_W−1 the counter holds its value.

## Structure
- Package fpro_arb_pkg holds the state enum (IDLE/ISSUE/ACK) and the default ADDR_W/DATA_W constants.
- One sub-module, rr_arb2: combinational 2-way winner select from req[1:0], last_grant and RR_EN.
- The top-level module contains the FSM, command/data registers and counters.

## Test plan
- Single read: m0_req with addr=0x00040 and fp_rd_data=0xDEADBEEF → fp_rd pulses at n+1 with fp_addr=0x00040; m0_ack and rd_data=0xDEADBEEF at n+2.
- Single write: m1 writes 0x12345678 to 0x00081 → fp_wr=1, fp_wr_data=0x12345678 for one cycle; m1_ack at n+2; rd_data unchanged.
- Contention, RR_EN=1: both masters request from reset for 4 transactions → grant order 0,1,0,1; grant_cnt0=2, grant_cnt1=2; no two consecutive cs cycles.
- Contention, RR_EN=0: both masters request continuously → only m0 is acked while m0_req stays high; m1 is granted in the first IDLE after m0 drops req.
- Reset in ISSUE: assert reset during the cs cycle → cs, ack and busy are 0 immediately; after release the FSM is in IDLE and the counters are 0.
- Saturation with CNT_W=2: 5 m0 transactions → grant_cnt0=3.
